// File: rtl/fpga_bridge_pkg.sv
// Shared types and constants for the FPGA AXI4-Lite to APB bridge.
package fpga_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bridge_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/fpga_axil_apb_bridge.sv
// AXI4-Lite slave to APB master bridge, one transaction outstanding.
// Writes and reads alternate on collision; a stuck APB slave is aborted
// after TIMEOUT_CYCLES ACCESS cycles with SLVERR.
module fpga_axil_apb_bridge
    import fpga_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int USER_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              core_clk,
    input  logic              cptra_rst_b,

    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,

    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,

    input  logic [USER_W-1:0] pauser_i,

    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [2:0]        PPROT,
    output logic [USER_W-1:0] PAUSER,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_e    state;
    logic             prio_write;   // 1: write wins the next collision
    logic [CNT_W-1:0] access_cnt;
    logic [1:0]       resp;
    logic             wr_elig;
    logic             rd_elig;
    logic             wr_go;
    logic             rd_go;

    // Acceptance is decided combinationally so ready coincides with valid;
    // reset gating keeps the readies low while reset is held.
    assign wr_elig = s_axi_awvalid & s_axi_wvalid;
    assign rd_elig = s_axi_arvalid;
    assign wr_go   = cptra_rst_b & (state == IDLE) & wr_elig & (prio_write | ~rd_elig);
    assign rd_go   = cptra_rst_b & (state == IDLE) & rd_elig & ~wr_go;

    assign s_axi_awready = wr_go;
    assign s_axi_wready  = wr_go;
    assign s_axi_arready = rd_go;
    assign s_axi_bresp   = resp;
    assign s_axi_rresp   = resp;

    // Bridge FSM: capture on acceptance, APB setup/access, hold response until taken.
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state        <= IDLE;
            prio_write   <= 1'b1;
            access_cnt   <= '0;
            resp         <= AXI_RESP_OKAY;
            s_axi_rdata  <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            PPROT        <= '0;
            PAUSER       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_go) begin
                        PADDR      <= s_axi_awaddr;
                        PPROT      <= s_axi_awprot;
                        PWDATA     <= s_axi_wdata;
                        PAUSER     <= pauser_i;
                        PWRITE     <= 1'b1;
                        prio_write <= 1'b0;
                        if (s_axi_wstrb != 4'hF) begin
                            // Partial writes cannot be expressed on this APB port
                            resp         <= AXI_RESP_SLVERR;
                            s_axi_bvalid <= 1'b1;
                            state        <= RESP;
                        end else begin
                            PSEL  <= 1'b1;
                            state <= SETUP;
                        end
                    end else if (rd_go) begin
                        PADDR      <= s_axi_araddr;
                        PPROT      <= s_axi_arprot;
                        PAUSER     <= pauser_i;
                        PWRITE     <= 1'b0;
                        prio_write <= 1'b1;
                        PSEL       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE    <= 1'b1;
                    access_cnt <= '0;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        resp    <= PSLVERR ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        if (PWRITE) begin
                            s_axi_bvalid <= 1'b1;
                        end else begin
                            s_axi_rdata  <= PRDATA;
                            s_axi_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else if (access_cnt == CNT_LAST) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        resp    <= AXI_RESP_SLVERR;
                        if (PWRITE) begin
                            s_axi_bvalid <= 1'b1;
                        end else begin
                            s_axi_rdata  <= '0;
                            s_axi_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        access_cnt <= access_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if ((s_axi_bvalid & s_axi_bready) | (s_axi_rvalid & s_axi_rready)) begin
                        s_axi_bvalid <= 1'b0;
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_axil_apb_bridge.sv
// Randomized bench for fpga_axil_apb_bridge with a transaction-level model:
// each accepted transfer is described by its acceptance cycle, the slave wait
// count chosen by the bench and the resulting response; expected outputs are
// derived from the cycle offset since acceptance.
module tb_fpga_axil_apb_bridge;

    logic        core_clk;
    logic        cptra_rst_b;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] pauser_i;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [2:0]  PPROT;
    logic [31:0] PAUSER;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    fpga_axil_apb_bridge dut (
        .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .pauser_i(pauser_i),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PPROT(PPROT), .PAUSER(PAUSER),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int checks = 0;
    int errors = 0;

    // Model of the outstanding transaction
    bit          m_busy = 0;
    bit          m_write = 0;
    bit          m_bad = 0;
    bit          m_tmo = 0;
    bit          m_err = 0;
    bit          m_prio_w = 1;
    int          m_since = 0;
    int          m_k = 0;
    int          m_wait = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    logic [31:0] m_user = 0;
    logic [31:0] m_prdata = 0;
    logic [2:0]  m_prot = 0;

    // Slave behaviour for the next accepted transaction
    int          cfg_wait = 0;
    bit          cfg_err = 0;
    logic [31:0] cfg_prdata = 0;

    bit          force_rdy = 0;
    int          pen_cnt = 0;
    int          psel_cnt = 0;
    logic [3:0]  acc_hist = 0;

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic new_cfg();
        cfg_wait   = ($urandom % 40 == 0) ? 256 + int'($urandom % 8) : int'($urandom % 5);
        cfg_err    = $urandom % 4 == 0;
        cfg_prdata = $urandom;
    endtask

    // Per-cycle comparison against the model, then advance the model one cycle
    always @(negedge core_clk) begin : cmp
        bit ea, er, ps, pe, bv, rv;
        int rs;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        if (!cptra_rst_b) begin
            check("rst_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                               s_axi_rvalid, PSEL, PENABLE, PWRITE}, 0);
            check("rst_resp", {s_axi_bresp, s_axi_rresp}, 0);
            check("rst_rdata", s_axi_rdata, 0);
            check("rst_paddr", PADDR, 0);
            check("rst_pwdata", PWDATA, 0);
            check("rst_pprot_pauser", {PPROT, PAUSER}, 0);
            m_busy   = 0;
            m_prio_w = 1;
        end else begin
            ea = !m_busy && s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || m_prio_w);
            er = !m_busy && s_axi_arvalid && !ea;
            rs = m_bad ? 1 : 2 + m_k;
            ps = m_busy && !m_bad && m_since >= 1 && m_since < 2 + m_k;
            pe = m_busy && !m_bad && m_since >= 2 && m_since < 2 + m_k;
            bv = m_busy && m_write && m_since >= rs;
            rv = m_busy && !m_write && m_since >= rs;
            e_resp  = (m_bad || m_tmo || m_err) ? 2'b10 : 2'b00;
            e_rdata = m_tmo ? 32'h0 : m_prdata;

            check("awready", s_axi_awready, ea);
            check("wready", s_axi_wready, ea);
            check("arready", s_axi_arready, er);
            check("psel", PSEL, ps);
            check("penable", PENABLE, pe);
            check("bvalid", s_axi_bvalid, bv);
            check("rvalid", s_axi_rvalid, rv);
            if (ps) begin
                check("paddr", PADDR, m_addr);
                check("pprot", PPROT, m_prot);
                check("pauser", PAUSER, m_user);
                check("pwrite", PWRITE, m_write);
                if (m_write) check("pwdata", PWDATA, m_wdata);
            end
            if (bv) check("bresp", s_axi_bresp, e_resp);
            if (rv) begin
                check("rresp", s_axi_rresp, e_resp);
                check("rdata", s_axi_rdata, e_rdata);
            end
            if (PENABLE) pen_cnt++;
            if (PSEL) psel_cnt++;

            if (m_busy) begin
                if ((bv && s_axi_bready) || (rv && s_axi_rready)) m_busy = 0;
                else m_since++;
            end else if (ea || er) begin
                m_write  = ea;
                m_addr   = ea ? s_axi_awaddr : s_axi_araddr;
                m_prot   = ea ? s_axi_awprot : s_axi_arprot;
                m_wdata  = s_axi_wdata;
                m_bad    = ea && (s_axi_wstrb != 4'hF);
                m_user   = pauser_i;
                m_wait   = cfg_wait;
                m_tmo    = cfg_wait >= 256;
                m_k      = m_tmo ? 256 : cfg_wait + 1;
                m_err    = cfg_err;
                m_prdata = cfg_prdata;
                m_prio_w = !ea;
                m_busy   = 1;
                m_since  = 1;
                pen_cnt  = 0;
                psel_cnt = 0;
                acc_hist = {acc_hist[2:0], ea};
            end
        end
    end

    // APB slave: waits m_wait ACCESS cycles, noise everywhere it must be ignored
    initial forever begin
        @(posedge core_clk); #1;
        pauser_i = $urandom;
        if (m_busy && !m_bad && m_since >= 2 && m_since < 2 + m_k) begin
            if (m_since - 2 == m_wait) begin
                PREADY = 1'b1; PSLVERR = m_err; PRDATA = m_prdata;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
            end
        end else begin
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        end
        if (!force_rdy) begin
            s_axi_bready = ($urandom % 3) != 0;
            s_axi_rready = ($urandom % 3) != 0;
        end
    end

    task automatic present(input bit dw, input bit dr, input logic [31:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra);
        bit pw, pr, hw, hr;
        int n;
        s_axi_awaddr = wa; s_axi_awprot = 3'($urandom); s_axi_wdata = wd; s_axi_wstrb = ws;
        s_axi_araddr = ra; s_axi_arprot = 3'($urandom);
        s_axi_awvalid = dw; s_axi_wvalid = dw; s_axi_arvalid = dr;
        pw = dw; pr = dr; n = 0;
        while ((pw || pr) && n < 2000) begin
            @(negedge core_clk);
            hw = s_axi_awvalid && s_axi_awready && s_axi_wready;
            hr = s_axi_arvalid && s_axi_arready;
            @(posedge core_clk); #1;
            if (hw) begin s_axi_awvalid = 0; s_axi_wvalid = 0; pw = 0; new_cfg(); end
            if (hr) begin s_axi_arvalid = 0; pr = 0; new_cfg(); end
            n++;
        end
        check("accept_bound", n >= 2000, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 3000) begin @(negedge core_clk); n++; end
        check("idle_bound", n >= 3000, 0);
        @(posedge core_clk); #1;
    endtask

    initial begin : main
        int kind, n;
        logic [3:0] st;
        cptra_rst_b = 0;
        s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0; s_axi_wdata = 0;
        s_axi_wstrb = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = 0;
        s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0; pauser_i = 0;
        PRDATA = 0; PREADY = 0; PSLVERR = 0;
        new_cfg();
        repeat (3) @(posedge core_clk);
        #1 cptra_rst_b = 1;
        repeat (2) @(posedge core_clk); #1;

        // Two back-to-back collisions: W, R, then W again, then R
        present(1, 1, 32'h1000_0000, 32'h1111_1111, 4'hF, 32'h2000_0000);
        present(1, 1, 32'h1000_0004, 32'h2222_2222, 4'hF, 32'h2000_0004);
        wait_idle();
        check("collision_order", acc_hist, 4'b1010);

        // Single write with zero-wait slave: SETUP@1, ACCESS@2, bvalid@3
        cfg_wait = 0; cfg_err = 0;
        present(1, 0, 32'h3000_0000, 32'hA5A5_5A5A, 4'hF, 0);
        @(negedge core_clk);
        check("w_c1_sel", {PSEL, PENABLE}, 2'b10);
        check("w_c1_pwdata", PWDATA, 32'hA5A5_5A5A);
        @(negedge core_clk);
        check("w_c2_sel", {PSEL, PENABLE}, 2'b11);
        @(negedge core_clk);
        check("w_c3_bvalid", {s_axi_bvalid, s_axi_bresp}, 3'b100);
        wait_idle();
        check("w_access_cycles", pen_cnt, 1);

        // Read with 5 wait cycles
        cfg_wait = 5; cfg_err = 0; cfg_prdata = 32'h1234_5678;
        present(0, 1, 0, 0, 4'hF, 32'h3002_0000);
        n = 0;
        while (!s_axi_rvalid && n < 30) begin
            @(negedge core_clk); n++;
            if (PSEL) check("r_paddr", PADDR, 32'h3002_0000);
        end
        check("r_rdata", s_axi_rdata, 32'h1234_5678);
        check("r_rresp", s_axi_rresp, 2'b00);
        check("r_access_cycles", pen_cnt, 6);
        wait_idle();

        // Read timeout
        cfg_wait = 300;
        present(0, 1, 0, 0, 4'hF, 32'h3003_0000);
        n = 0;
        while (!s_axi_rvalid && n < 400) begin @(negedge core_clk); n++; end
        check("tmo_access_cycles", pen_cnt, 256);
        check("tmo_resp", {PSEL, s_axi_rvalid, s_axi_rresp}, 4'b0110);
        check("tmo_rdata", s_axi_rdata, 0);
        wait_idle();

        // Partial-strobe write bypasses APB
        present(1, 0, 32'h3000_0008, 32'hDEAD_BEEF, 4'h3, 0);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge core_clk); n++; end
        check("strb_bresp", {s_axi_bvalid, s_axi_bresp}, 3'b110);
        check("strb_no_psel", psel_cnt, 0);
        wait_idle();

        // Response held while bready stays low
        force_rdy = 1; s_axi_bready = 0; s_axi_rready = 0;
        cfg_wait = 0; cfg_err = 1;
        present(1, 0, 32'h3000_000C, 32'h0F0F_0F0F, 4'hF, 0);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge core_clk); n++; end
        for (int i = 0; i < 10; i++) begin
            check("hold_bvalid", {s_axi_bvalid, s_axi_bresp}, 3'b110);
            @(negedge core_clk);
        end
        @(posedge core_clk); #1;
        s_axi_bready = 1; force_rdy = 0;
        wait_idle();

        // Reset during ACCESS discards the transfer
        cfg_wait = 50;
        present(1, 0, 32'h3000_0010, 32'h5555_AAAA, 4'hF, 0);
        repeat (2) @(negedge core_clk);
        @(posedge core_clk); #2;
        cptra_rst_b = 0;
        #1;
        check("arst_apb", {PSEL, PENABLE, PWRITE}, 0);
        check("arst_paddr", PADDR, 0);
        check("arst_pwdata", PWDATA, 0);
        check("arst_valid", {s_axi_bvalid, s_axi_rvalid}, 0);
        repeat (2) @(posedge core_clk);
        #1 cptra_rst_b = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge core_clk);
            check("post_rst_quiet", {s_axi_bvalid, s_axi_rvalid, PSEL}, 0);
        end
        @(posedge core_clk); #1;

        // Randomized traffic
        new_cfg();
        for (int i = 0; i < 250; i++) begin
            kind = int'($urandom % 4);
            st = ($urandom % 6 == 0) ? 4'($urandom % 15) : 4'hF;
            present(kind != 2, kind >= 2, $urandom, $urandom, st, $urandom);
        end
        wait_idle();
        repeat (3) @(posedge core_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpga_axil_apb_bridge.md
FPGA_AXIL_APB_BRIDGE -- requirements
Module: fpga_axil_apb_bridge

Interface
REQ-001 The parameters SHALL be, one per line:
- ADDR_W, default 32, width of the AXI and APB address.
- DATA_W, default 32, width of the data path; only 32 is supported.
- USER_W, default 32, width of PAUSER.
- TIMEOUT_CYCLES, default 256, maximum length of the ACCESS phase before the bridge aborts.
REQ-002 The clock and reset SHALL be: one clock; reset is asynchronous and active-low.
- core_clk, in, 1, clock.
- cptra_rst_b, in, 1, asynchronous active-low reset.
REQ-003 The AXI write channels SHALL be:
- s_axi_awaddr/awprot/awvalid, in, ADDR_W/3/1, write address.
- s_axi_awready, out, 1.
- s_axi_wdata/wstrb/wvalid, in, DATA_W/4/1, write data.
- s_axi_wready, out, 1.
- s_axi_bresp/bvalid, out, 2/1, write response.
- s_axi_bready, in, 1.
REQ-004 The AXI read channels SHALL be:
- s_axi_araddr/arprot/arvalid, in, ADDR_W/3/1, read address.
- s_axi_arready, out, 1.
- s_axi_rdata/rresp/rvalid, out, DATA_W/2/1, read data.
- s_axi_rready, in, 1.
REQ-005 pauser_i, in, USER_W, SHALL be the user value driven onto PAUSER for every transfer.
REQ-006 The APB master outputs SHALL be:
- PADDR, out, ADDR_W.
- PSEL, PENABLE, PWRITE, out, 1 each.
- PWDATA, out, DATA_W.
- PPROT, out, 3.
- PAUSER, out, USER_W.
REQ-007 The APB master inputs SHALL be:
- PRDATA, in, DATA_W.
- PREADY, PSLVERR, in, 1 each.

Function
REQ-008 The bridge SHALL use the states IDLE, SETUP, ACCESS and RESP, with at most one transaction outstanding.
REQ-009 In IDLE, a write is eligible only when awvalid and wvalid are both high; awready and wready SHALL pulse together for one cycle on acceptance.
REQ-010 In IDLE, a read is eligible when arvalid is high; arready SHALL pulse for one cycle on acceptance.
REQ-011 When a write and a read are eligible in the same cycle, the bridge SHALL serve the type not served last. A priority flag records this; it resets to write-first.
REQ-012 On acceptance the bridge SHALL register the address, prot, wdata and pauser_i and go to SETUP. Exception: a write with wstrb != 4'hF SHALL skip APB and go to RESP with SLVERR (2'b10).
REQ-013 SETUP SHALL last exactly one cycle: PSEL=1, PENABLE=0. Next state is ACCESS.
REQ-014 ACCESS SHALL drive PSEL=1 and PENABLE=1 until PREADY=1; it then exits to RESP in the following cycle.
REQ-015 PADDR, PWRITE, PWDATA, PPROT and PAUSER SHALL hold stable from SETUP through the last ACCESS cycle.
REQ-016 The response SHALL be PSLVERR sampled with PREADY: 1 gives SLVERR (2'b10), 0 gives OKAY (2'b00). On a read, PRDATA SHALL be captured into rdata at that edge.
REQ-017 A cycle counter SHALL count ACCESS cycles. If it reaches TIMEOUT_CYCLES with PREADY low, the bridge SHALL deassert PSEL/PENABLE and go to RESP with SLVERR; rdata is 0 in that case.
REQ-018 In RESP, bvalid (write) or rvalid (read) SHALL stay high with stable bresp/rresp/rdata until bready/rready. The state returns to IDLE in the cycle after the handshake.
REQ-019 Minimum latency SHALL be: acceptance at cycle 0, SETUP at 1, ACCESS at 2; PREADY=1 at cycle 2 gives bvalid/rvalid at cycle 3.
REQ-020 A new transaction SHALL NOT be accepted in the same cycle as the response handshake.
REQ-021 PSEL SHALL be 0 in IDLE and RESP.

Reset
REQ-022 Asserting cptra_rst_b low at any time SHALL asynchronously force:
- state to IDLE;
- all ready/valid/PSEL/PENABLE/PWRITE outputs to 0;
- resp, rdata, PADDR, PWDATA, PPROT, PAUSER and the counter to 0;
- the priority flag to write-first.
REQ-023 A transaction in flight at reset SHALL be discarded with no response.

Structure
REQ-024 The shared package fpga_bridge_pkg SHALL hold:
- the state enum bridge_state_e;
- the AXI response constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
REQ-025 The block SHALL be a single module with no sub-module. Its PADDR..PAUSER outputs SHALL connect directly to the APB inputs of the FPGA Caliptra wrapper.

Verification
REQ-026 Write 0x3000_0000 with data 0xA5A5_5A5A, wstrb F; PREADY tied 1 -> one SETUP and one ACCESS cycle with PWDATA=0xA5A5_5A5A; bvalid at cycle 3 with bresp=00.
REQ-027 Read 0x3002_0000; PREADY low for 5 ACCESS cycles, then high with PRDATA=0x1234_5678 -> rdata=0x1234_5678, rresp=00, PADDR stable throughout.
REQ-028 Write and read eligible in the same cycle, twice in succession -> the write is served first, then the read; the next collision serves the write again.
REQ-029 PREADY held 0 -> exactly 256 ACCESS cycles, then PSEL drops and rresp=10 with rdata=0. A write with wstrb=4'h3 -> no PSEL and bresp=10.
REQ-030 cptra_rst_b asserted during ACCESS, and bready held 0 for 10 cycles in RESP -> all outputs 0 immediately with no stale response after release; bvalid and bresp held stable for the 10 cycles.
